// File: rtl/wb_pkg.sv
// Shared encodings and types for the RV32I writeback stage.
package wb_pkg;

  // wb_sel encoding; the value 3 falls through to the ALU result.
  localparam logic [1:0] WB_MEM = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  // Load funct3 encodings; 011/110/111 pass the word through unchanged.
  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_e;

  // Fields of an accepted instruction that are still needed once its load
  // response arrives.
  typedef struct packed {
    logic [4:0] rd;
    logic       regwen;
    logic [2:0] ld_st_sel;
    logic [1:0] addr_lo;
  } wb_hold_t;

endpackage

// File: rtl/load_formatter.sv
// Selects and extends the byte/halfword addressed by a load from the
// returned memory word.
module load_formatter
  import wb_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [2:0]  ld_st_sel_i,
  input  logic [1:0]  addr_lo_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and halfword; addr_lo[0] is ignored for halves.
  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  // Extend according to the load type.
  always_comb begin
    case (ld_st_sel_i)
      LD_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      LD_H:    data_o = {{16{half_sel[15]}}, half_sel};
      LD_BU:   data_o = {24'd0, byte_sel};
      LD_HU:   data_o = {16'd0, half_sel};
      LD_W:    data_o = rdata_i;
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: accepts retiring instructions from MEM, waits for load
// data, and drives the single register-file write port.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   IDLE      | ready for the next instruction; non-loads retire here
//   WAIT_LOAD | load accepted, holding until dmem_rvalid_i arrives
module wb_stage
  import wb_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             reset_n,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [4:0]       rd_i,
  input  logic             regWEn_i,
  input  logic             is_load_i,
  input  logic [1:0]       wb_sel_i,
  input  logic [2:0]       ld_st_sel_i,
  input  logic [1:0]       addr_lo_i,
  input  logic [31:0]      alu_result_i,
  input  logic [31:0]      pc_plus4_i,
  input  logic             dmem_rvalid_i,
  input  logic [31:0]      dmem_rdata_i,
  output logic [4:0]       rsW_o,
  output logic [31:0]      dataW_o,
  output logic             regWEn_o,
  output logic             retire_o,
  output logic [CNT_W-1:0] instret_o,
  output logic             err_o
);

  wb_state_e        state_q, state_d;
  wb_hold_t         hold_q, hold_d;
  logic [4:0]       rsw_q, rsw_d;
  logic [31:0]      data_q, data_d;
  logic             wen_q, wen_d;
  logic             retire_q, retire_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             err_q, err_d;
  logic [31:0]      fmt_data;
  logic [31:0]      nonload_data;

  load_formatter u_fmt (
    .rdata_i     (dmem_rdata_i),
    .ld_st_sel_i (hold_q.ld_st_sel),
    .addr_lo_i   (hold_q.addr_lo),
    .data_o      (fmt_data)
  );

  assign ready_o = (state_q == IDLE);

  // Non-load result select; a non-load has no memory data, so WB_MEM and
  // the unused code both fall back to the ALU result.
  always_comb begin
    if (wb_sel_i == WB_PC4) nonload_data = pc_plus4_i;
    else                    nonload_data = alu_result_i;
  end

  // Next-state logic for the handshake FSM and the write-port registers.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    rsw_d    = rsw_q;
    data_d   = data_q;
    wen_d    = 1'b0;
    retire_d = 1'b0;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (dmem_rvalid_i) err_d = 1'b1;
        if (valid_i) begin
          hold_d = '{rd: rd_i, regwen: regWEn_i,
                     ld_st_sel: ld_st_sel_i, addr_lo: addr_lo_i};
          if (is_load_i) begin
            state_d = WAIT_LOAD;
          end else begin
            rsw_d    = rd_i;
            data_d   = nonload_data;
            wen_d    = regWEn_i && (rd_i != 5'd0);
            retire_d = 1'b1;
          end
        end
      end
      WAIT_LOAD: begin
        if (dmem_rvalid_i) begin
          rsw_d    = hold_q.rd;
          data_d   = fmt_data;
          wen_d    = hold_q.regwen && (hold_q.rd != 5'd0);
          retire_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire_d};
  end

  // State registers with synchronous active-low reset; reset also drops
  // any pending load together with a response arriving in the same cycle.
  always_ff @(posedge clk_i) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      rsw_q     <= '0;
      data_q    <= '0;
      wen_q     <= 1'b0;
      retire_q  <= 1'b0;
      instret_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      rsw_q     <= rsw_d;
      data_q    <= data_d;
      wen_q     <= wen_d;
      retire_q  <= retire_d;
      instret_q <= instret_d;
      err_q     <= err_d;
    end
  end

  assign rsW_o     = rsw_q;
  assign dataW_o   = data_q;
  assign regWEn_o  = wen_q;
  assign retire_o  = retire_q;
  assign instret_o = instret_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: expected register-file writes are queued as
// instructions are issued and checked by a monitor on every retire pulse.
module tb_wb_stage;

  logic        clk_i = 1'b0;
  logic        reset_n;
  logic        valid_i;
  logic        ready_o;
  logic [4:0]  rd_i;
  logic        regWEn_i;
  logic        is_load_i;
  logic [1:0]  wb_sel_i;
  logic [2:0]  ld_st_sel_i;
  logic [1:0]  addr_lo_i;
  logic [31:0] alu_result_i;
  logic [31:0] pc_plus4_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic [4:0]  rsW_o;
  logic [31:0] dataW_o;
  logic        regWEn_o;
  logic        retire_o;
  logic [31:0] instret_o;
  logic        err_o;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        wen;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  wb_stage #(.CNT_W(32)) dut (
    .clk_i         (clk_i),
    .reset_n       (reset_n),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .rd_i          (rd_i),
    .regWEn_i      (regWEn_i),
    .is_load_i     (is_load_i),
    .wb_sel_i      (wb_sel_i),
    .ld_st_sel_i   (ld_st_sel_i),
    .addr_lo_i     (addr_lo_i),
    .alu_result_i  (alu_result_i),
    .pc_plus4_i    (pc_plus4_i),
    .dmem_rvalid_i (dmem_rvalid_i),
    .dmem_rdata_i  (dmem_rdata_i),
    .rsW_o         (rsW_o),
    .dataW_o       (dataW_o),
    .regWEn_o      (regWEn_o),
    .retire_o      (retire_o),
    .instret_o     (instret_o),
    .err_o         (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_exp(input logic [4:0] rd, input logic [31:0] data, input logic wen);
    exp_t e;
    e.rd = rd; e.data = data; e.wen = wen;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic [4:0] rd, input logic wen, input logic ld,
                       input logic [1:0] sel, input logic [2:0] f3, input logic [1:0] alo,
                       input logic [31:0] alu, input logic [31:0] pc4);
    valid_i = 1'b1; rd_i = rd; regWEn_i = wen; is_load_i = ld; wb_sel_i = sel;
    ld_st_sel_i = f3; addr_lo_i = alo; alu_result_i = alu; pc_plus4_i = pc4;
  endtask

  // Load with a given response delay: accept, wait n cycles, return rdata.
  task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] alo,
                         input int wait_cycles, input logic [31:0] rdata, input string name);
    drive(rd, 1'b1, 1'b1, 2'd1, f3, alo, 32'hDEAD_BEEF, 32'h0);
    tick();
    valid_i = 1'b0;
    for (int i = 0; i < wait_cycles; i++) begin
      check({name, " ready_o low while waiting"}, {31'd0, ready_o}, 32'd0);
      tick();
    end
    dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata;
    tick();
    dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
  endtask

  // Monitor: each retire pulse must match the oldest queued write.
  always @(negedge clk_i) begin
    if (retire_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected retire", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb rsW_o",    {27'd0, rsW_o},    {27'd0, e.rd});
        check("sb dataW_o",  dataW_o,           e.data);
        check("sb regWEn_o", {31'd0, regWEn_o}, {31'd0, e.wen});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; valid_i = 1'b0; rd_i = '0; regWEn_i = 1'b0; is_load_i = 1'b0;
    wb_sel_i = '0; ld_st_sel_i = '0; addr_lo_i = '0; alu_result_i = '0; pc_plus4_i = '0;
    dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    tick(); tick();
    check("reset ready_o",   {31'd0, ready_o},  32'd1);
    check("reset regWEn_o",  {31'd0, regWEn_o}, 32'd0);
    check("reset dataW_o",   dataW_o,           32'd0);
    check("reset instret_o", instret_o,         32'd0);
    check("reset err_o",     {31'd0, err_o},    32'd0);
    reset_n = 1'b1;
    tick();

    // 1. ALU then PC+4, back to back
    push_exp(5'd5, 32'h0000_1234, 1'b1);
    drive(5'd5, 1'b1, 1'b0, 2'd1, 3'd0, 2'd0, 32'h0000_1234, 32'h0000_0100);
    tick();
    push_exp(5'd6, 32'h0000_0104, 1'b1);
    drive(5'd6, 1'b1, 1'b0, 2'd2, 3'd0, 2'd0, 32'h0000_9999, 32'h0000_0104);
    tick();
    valid_i = 1'b0;
    check("t1 instret_o", instret_o, 32'd2);
    tick();
    check("idle regWEn_o", {31'd0, regWEn_o}, 32'd0);
    check("idle dataW_o holds", dataW_o, 32'h0000_0104);

    // 2. LB at addr 3, response three cycles later
    push_exp(5'd7, 32'hFFFF_FF80, 1'b1);
    do_load(5'd7, 3'b000, 2'd3, 3, 32'h80FF_1122, "t2");
    check("t2 ready_o after", {31'd0, ready_o}, 32'd1);
    check("t2 instret_o", instret_o, 32'd3);
    tick();

    // 3. LHU then LH, upper halfword
    push_exp(5'd8, 32'h0000_8001, 1'b1);
    do_load(5'd8, 3'b101, 2'd2, 1, 32'h8001_F00F, "t3 lhu");
    push_exp(5'd9, 32'hFFFF_8001, 1'b1);
    do_load(5'd9, 3'b001, 2'd2, 0, 32'h8001_F00F, "t3 lh");
    // extra formatter corners: LBU byte 1, word passthrough via funct3 111
    push_exp(5'd10, 32'h0000_00F0, 1'b1);
    do_load(5'd10, 3'b100, 2'd1, 2, 32'h1234_F00F, "t3 lbu");
    push_exp(5'd11, 32'h8001_F00F, 1'b1);
    do_load(5'd11, 3'b111, 2'd1, 1, 32'h8001_F00F, "t3 w111");
    check("t3 instret_o", instret_o, 32'd7);

    // 4. write to x0 and a store: both retire without a write
    push_exp(5'd0, 32'h0000_0055, 1'b0);
    drive(5'd0, 1'b1, 1'b0, 2'd1, 3'd0, 2'd0, 32'h0000_0055, 32'h0);
    tick();
    push_exp(5'd3, 32'h0000_AAAA, 1'b0);
    drive(5'd3, 1'b0, 1'b0, 2'd1, 3'd0, 2'd0, 32'h0000_AAAA, 32'h0);
    tick();
    valid_i = 1'b0;
    check("t4 instret_o", instret_o, 32'd9);
    tick();

    // 5. reset during WAIT_LOAD coinciding with rvalid
    drive(5'd12, 1'b1, 1'b1, 2'd0, 3'b010, 2'd0, 32'h0, 32'h0);
    tick();
    valid_i = 1'b0;
    check("t5 ready_o in wait", {31'd0, ready_o}, 32'd0);
    reset_n = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hCAFE_F00D;
    tick();
    reset_n = 1'b1; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
    check("t5 regWEn_o",  {31'd0, regWEn_o}, 32'd0);
    check("t5 rsW_o",     {27'd0, rsW_o},    32'd0);
    check("t5 dataW_o",   dataW_o,           32'd0);
    check("t5 ready_o",   {31'd0, ready_o},  32'd1);
    check("t5 instret_o", instret_o,         32'd0);
    tick();
    check("t5 no late write", {31'd0, retire_o}, 32'd0);

    // 6. spurious rvalid while idle
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h1111_2222;
    tick();
    dmem_rvalid_i = 1'b0;
    check("t6 err_o set",     {31'd0, err_o},    32'd1);
    check("t6 regWEn_o",      {31'd0, regWEn_o}, 32'd0);
    check("t6 instret_o",     instret_o,         32'd0);
    check("t6 ready_o",       {31'd0, ready_o},  32'd1);
    tick(); tick();
    check("t6 err_o sticky",  {31'd0, err_o},    32'd1);
    check("t6 instret_o hold", instret_o,        32'd0);

    tick();
    check("scoreboard drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
Writeback stage of the pipelined RV32I core; the write-side counterpart of the decode stage's register-file read.
- Accepts retiring instructions from MEM through a valid/ready handshake.
- Waits for data-memory load responses that arrive after a variable number of cycles, and aligns and extends the loaded data.
- Drives the single register-file write port (rsW_o, dataW_o, regWEn_o) back to decode.
- Counts retired instructions.

Parameters:
CNT_W, 32, width of the retired-instruction counter instret_o (wraps modulo 2^CNT_W).

Ports:
clk_i  in  1  clock; all state updates on the rising edge
reset_n  in  1  synchronous, active-low reset
valid_i  in  1  MEM stage presents an instruction
ready_o  out  1  WB can accept this cycle (combinational, = state IDLE)
rd_i  in  5  destination register
regWEn_i  in  1  instruction writes rd
is_load_i  in  1  instruction is a load (needs dmem response)
wb_sel_i  in  2  0=MEM data, 1=ALU result, 2=PC+4, 3=treated as ALU
ld_st_sel_i  in  3  funct3 of the load
addr_lo_i  in  2  load byte address [1:0]
alu_result_i  in  32  ALU result
pc_plus4_i  in  32  PC+4 of the instruction
dmem_rvalid_i  in  1  load data valid (single-cycle pulse)
dmem_rdata_i  in  32  aligned 32-bit memory word
rsW_o  out  5  register-file write address
dataW_o  out  32  register-file write data
regWEn_o  out  1  register-file write enable
retire_o  out  1  one-cycle pulse per retired instruction
instret_o  out  CNT_W  retired-instruction count
err_o  out  1  sticky: dmem_rvalid_i seen while not in WAIT_LOAD

Behaviour:
- Reset (reset_n=0 at a rising edge): state=IDLE; rsW_o=0, dataW_o=0, regWEn_o=0, retire_o=0, instret_o=0, err_o=0. Reset during WAIT_LOAD discards the pending load, including any rvalid in that cycle.
- States: IDLE and WAIT_LOAD. ready_o=1 only in IDLE.
- Accept: valid_i && ready_o at a rising edge. The instruction's fields are captured into an internal holding register.
- Non-load accept (is_load_i=0):
  - At the same edge, load the output registers: rsW_o=rd_i; dataW_o=mux(wb_sel_i); regWEn_o=regWEn_i && (rd_i!=0); retire_o=1.
  - State stays IDLE, so back-to-back accepts give one write per cycle.
  - Latency: one cycle from accept to write visible at the register file.
- Load accept (is_load_i=1):
  - Capture rd, regWEn, ld_st_sel and addr_lo; go to WAIT_LOAD. regWEn_o=0 and retire_o=0 at that edge.
  - A load with regWEn_i=0 or rd=0 still waits for its response, to keep ordering.
- WAIT_LOAD with dmem_rvalid_i=1:
  - At that edge: dataW_o=formatted data; rsW_o=held rd; regWEn_o=held regWEn && rd!=0; retire_o=1; state=IDLE.
  - valid_i in this cycle is not accepted because ready_o=0.
- WAIT_LOAD without rvalid: hold indefinitely; no timeout.
- Idle cycles: regWEn_o=0 and retire_o=0. rsW_o and dataW_o hold their last values.
- Load formatting, with b = byte at addr_lo and h = halfword at addr_lo[1]:
  - 000 LB: sign-extended b
  - 001 LH: sign-extended h; addr_lo[0] is ignored
  - 010 LW: the full word
  - 100 LBU: zero-extended b
  - 101 LHU: zero-extended h
  - 011/110/111: the full word
- For a load, wb_sel_i is ignored; memory data is always written.
- instret_o increments by 1 on every retire_o pulse and wraps to 0.
- err_o sets on dmem_rvalid_i in IDLE (the pulse is otherwise ignored) and clears only on reset.

Decomposition:
- Package wb_pkg holds:
  - the wb_sel encoding constants (WB_MEM, WB_ALU, WB_PC4);
  - the load funct3 constants (LD_B, LD_H, LD_W, LD_BU, LD_HU);
  - the state enum (IDLE, WAIT_LOAD).
- Sub-module load_formatter: purely combinational; inputs rdata, ld_st_sel, addr_lo; output 32-bit data. It is unit-testable on its own.

Test Plan:
1. ALU back-to-back:
   - Stimulus: accept in consecutive cycles (rd=5, wb_sel=1, alu=0x1234), then (rd=6, wb_sel=2, pc_plus4=0x104).
   - Response: regWEn_o=1 in two consecutive cycles with (5, 0x00001234) then (6, 0x00000104); instret_o=2.
2. Delayed LB:
   - Stimulus: load accepted with ld_st_sel=000, addr_lo=3, rd=7; dmem_rvalid_i asserted 3 cycles later with rdata=0x80FF1122.
   - Response: ready_o=0 for those 3 cycles; a single write of (7, 0xFFFFFF80) in the cycle after rvalid.
3. LHU/LH:
   - Stimulus: rdata=0x8001F00F with addr_lo=2, first as LHU, then as LH.
   - Response: LHU writes 0x00008001; LH writes 0xFFFF8001.
4. rd=x0 and store:
   - Stimulus: ALU instruction to rd=0 with regWEn=1; then a store (regWEn=0, is_load=0).
   - Response: regWEn_o=0 for both; retire_o pulses twice; instret_o advances by 2.
5. Reset mid-load:
   - Stimulus: assert reset_n=0 during WAIT_LOAD, together with rvalid.
   - Response: no write; after reset, outputs=0, ready_o=1, instret_o=0.
6. Spurious rvalid:
   - Stimulus: dmem_rvalid_i=1 while in IDLE.
   - Response: err_o=1 and stays 1; no write; instret_o unchanged.
